uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `UartTx` transmitter between `NUM_REQ` byte producers (CPU console, debug monitor, boot loader, etc.). It accepts one byte at a time from a requester, latches it, and sequences the transmitter's `go`/`bsy` handshake. It then releases the transmitter back to idle before granting the next byte. A per-requester lock keeps ownership for multi-byte messages so they are not interleaved with other requesters' output.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..16.
- `START_TIMEOUT`, 15: cycles to wait for `uart_bsy` to rise after `uart_go` is asserted, range ≥ 2.
- `clk`  in  1: system clock; all state updates on posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NUM_REQ: requester k has a byte pending; level, held until `ack[k]`.
- `req_data`  in  8*NUM_REQ: byte of requester k at `[8k+7:8k]`; must be stable while `req[k]` is high and `ack[k]` has not yet pulsed.
- `lock`  in  NUM_REQ: requester k keeps the grant after its current byte if its `req[k]` is high again at the next arbitration.
- `ack`  out  NUM_REQ: one-cycle pulse; the byte is latched and the requester may present the next one.
- `done`  out  NUM_REQ: one-cycle pulse when the granted byte's stop bit has finished (`uart_bsy` fell).
- `err`  out  1: one-cycle pulse on start timeout.
- `grant_valid`  out  1: high from grant until release completes.
- `grant_id`  out  max(1,$clog2(NUM_REQ)): current or last owner.
- `uart_data`  out  8: to `UartTx.data`; held for the whole transmission.
- `uart_go`  out  1: to `UartTx.go`.
- `uart_bsy`  in  1: from `UartTx.bsy`. `UartTx` runs on negedge of the same `clk`, and its `rst` is tied to `!rst_n` at top level.

## Operation
- **IDLE:** if any `req` bit is high, select a winner.
  - If `lock[last]` and `req[last]` are both high, the winner is `last`.
  - Otherwise the winner is the first set bit scanning from `last+1`, wrapping modulo `NUM_REQ`.
  - On a winner:
    - `uart_data` ← that requester's byte.
    - `ack[w]` pulses.
    - `uart_go` ← 1, `grant_valid` ← 1, `grant_id` ← w, `last` ← w.
    - Go to **START**.
- **START:** `uart_go` stays high.
  - If `uart_bsy` == 1, go to **SENDING**.
  - If the counter reaches `START_TIMEOUT` with no `uart_bsy`: `uart_go` ← 0, `err` pulses, go to **RELEASE**.
- **SENDING:** when `uart_bsy` == 0:
  - `done[grant_id]` pulses.
  - `uart_go` ← 0.
  - Go to **RELEASE**.
- **RELEASE:** exactly one cycle with `uart_go` low, which lets `UartTx` leave its wait-for-go-low state on the intervening negedge.
  - `grant_valid` ← 0.
  - Go to **IDLE**.
- **Request changes:**
  - `req` withdrawn before grant: never selected, no `ack`.
  - `req` changes after `ack`: no effect on the byte in flight.
- **Reset (asynchronous assert):**
  - State → IDLE.
  - `uart_go`, `ack`, `done`, `err`, `grant_valid` → 0; `uart_data` → 0; `grant_id` → 0.
  - `last` → `NUM_REQ-1`, so requester 0 wins first.
  - Reset mid-transmission abandons the byte with no `done`.

## Timing
- `req` high at posedge n in IDLE:
  - `ack` and `uart_go` high after posedge n.
  - `UartTx` starts the start bit at negedge n+0.5.
  - `uart_bsy` is seen high at posedge n+1.
- Fall of `uart_bsy` seen at posedge m: `done` and `uart_go`=0 after m; RELEASE during m..m+1; next grant decided at posedge m+2.
- Minimum byte-to-byte spacing: 10·BIT_TIME + 3 cycles.
- At most one byte in flight; no internal queue.
- Simultaneous requests: strictly one winner per arbitration, and each requester waits at most `NUM_REQ-1` bytes unless a lock holder keeps requesting.
- A lock holder that drops `req` while `lock` is high loses priority; normal rotation resumes.

## Structure
- Shared package: the state encoding (IDLE, START, SENDING, RELEASE) and the round-robin pick helper.
- One sub-module is natural: `rr_pick`, combinational `NUM_REQ`-bit round-robin priority encoder taking `req` and `last` and returning `winner` and `any`. It is reusable by other shared-peripheral arbiters.
- The timeout counter is `$clog2(START_TIMEOUT+1)` bits and is cleared on entry to START.

## Test plan
- Single requester 0 sends 0x55 with `UartTx` `BIT_TIME`=4 → one `ack[0]`; line carries 0, 1,0,1,0,1,0,1,0, 1; `done[0]` pulses once; `uart_go` low for exactly one cycle before the next IDLE.
- `req`=4'b1111 with bytes 0xA0..0xA3 held continuously → transmit order 0xA0, 0xA1, 0xA2, 0xA3, then 0xA0 again.
- Requester 2 sends 3 bytes with `lock[2]`=1 while requester 1 also requests → 3 consecutive requester-2 bytes, then requester 1.
- `uart_bsy` tied low → `err` pulses exactly `START_TIMEOUT` cycles after `uart_go` rises; no `done`; next requester is granted after RELEASE.
- `rst_n` dropped mid-byte → all outputs reach reset values asynchronously; after release, requester 0 wins first.
- `req[3]` pulsed high for 1 cycle while requester 1 holds the grant → requester 3 is never acked.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: FSM state encoding and round-robin pick helper shared by the arbiter files
package uart_tx_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_SENDING = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Returns {any, winner}: first set bit of req scanning from last+1, wrapping modulo n.
    function automatic logic [4:0] rr_next(input logic [15:0] req, input logic [3:0] last, input int n);
        logic [4:0] r;
        r = '0;
        for (int i = 16; i >= 1; i--)
            if (i <= n && req[(int'(last) + i) % n])
                r = {1'b1, 4'((int'(last) + i) % n)};
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder over N requesters
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          any
);

    logic [4:0] r;

    assign r      = rr_next(16'(req), 4'(last), N);
    assign any    = r[4];
    assign winner = IW'(r[3:0]);

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UartTx between NUM_REQ byte producers with per-requester lock
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 15,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(START_TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   lock,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic                 grant_valid,
    output logic [IW-1:0]        grant_id,
    output logic [7:0]           uart_data,
    output logic                 uart_go,
    input  logic                 uart_bsy
);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] last;
    logic [IW-1:0] rr_w;
    logic [IW-1:0] win;
    logic          rr_any;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req    (req),
        .last   (last),
        .winner (rr_w),
        .any    (rr_any)
    );

    assign win = (lock[last] && req[last]) ? last : rr_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            last        <= IW'(NUM_REQ - 1);
            ack         <= '0;
            done        <= '0;
            err         <= 1'b0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            uart_data   <= '0;
            uart_go     <= 1'b0;
        end else begin
            ack  <= '0;
            done <= '0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: if (rr_any) begin
                    uart_data   <= req_data[{win, 3'b000} +: 8];
                    ack         <= NUM_REQ'(1) << win;
                    uart_go     <= 1'b1;
                    grant_valid <= 1'b1;
                    grant_id    <= win;
                    last        <= win;
                    cnt         <= '0;
                    state       <= ST_START;
                end
                ST_START: if (uart_bsy) begin
                    state <= ST_SENDING;
                end else if (cnt == CW'(START_TIMEOUT - 1)) begin
                    uart_go <= 1'b0;
                    err     <= 1'b1;
                    state   <= ST_RELEASE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                ST_SENDING: if (!uart_bsy) begin
                    done    <= NUM_REQ'(1) << grant_id;
                    uart_go <= 1'b0;
                    state   <= ST_RELEASE;
                end
                default: begin
                    grant_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench with a behavioural negedge UartTx (BIT_TIME=4)
module tb_uart_tx_arbiter;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  lock = '0;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        err;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [7:0]  uart_data;
    logic        uart_go;
    logic        uart_bsy;

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    logic [3:0] ack_seen = '0;
    logic tx_dead = 1'b0;

    logic       tx_line;
    int         st, tick, bitn;
    logic [9:0] sh, frame;

    uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .lock        (lock),
        .ack         (ack),
        .done        (done),
        .err         (err),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .uart_data   (uart_data),
        .uart_go     (uart_go),
        .uart_bsy    (uart_bsy)
    );

    always #5 clk = ~clk;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= 0; tick <= 0; bitn <= 0; uart_bsy <= 1'b0; tx_line <= 1'b1; sh <= '0;
        end else case (st)
            0: if (uart_go && !tx_dead) begin
                sh <= {1'b1, uart_data, 1'b0}; tx_line <= 1'b0; bitn <= 0; tick <= 0; uart_bsy <= 1'b1; st <= 1;
            end
            1: if (tick == 3) begin
                tick <= 0;
                if (bitn == 9) begin
                    uart_bsy <= 1'b0; tx_line <= 1'b1; st <= 2;
                end else begin
                    bitn <= bitn + 1; tx_line <= sh[bitn + 1];
                end
            end else tick <= tick + 1;
            default: if (!uart_go) st <= 0;
        endcase
    end

    always @(negedge clk)
        if (st == 1 && tick == 1) frame[bitn] <= tx_line;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        ack_seen <= ack_seen | ack;
        if (rst_n && done != 0) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $error("FAIL unexpected_done: observed=%0h expected=none", done);
            end else begin
                e = exp_q.pop_front();
                chk("done_id", 32'(done), 32'(4'b1 << e.id));
                chk("frame", 32'(frame), 32'({1'b1, e.data, 1'b0}));
            end
        end
    end

    task automatic wait_ack(input string tag, output logic [3:0] a);
        a = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ack != 0) begin a = ack; return; end
        end
        total++; bad++;
        $error("FAIL %s: observed=no_ack expected=ack", tag);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done != 0) return;
        end
        total++; bad++;
        $error("FAIL %s: observed=no_done expected=done", tag);
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) return;
        end
        total++; bad++;
        $error("FAIL %s: observed=%0d pending expected=0", tag, exp_q.size());
    endtask

    task automatic count_to_err(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!err && n < 50);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] a;
        int n, dc;
        repeat (3) @(negedge clk);
        chk("rst_go", 32'(uart_go), 0);
        chk("rst_gv", 32'(grant_valid), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_data", 32'(uart_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte 0x55 from requester 0
        req = 4'b0001; req_data[7:0] = 8'h55; exp_q.push_back('{0, 8'h55});
        wait_ack("t1_ack_wait", a);
        chk("t1_ack", 32'(a), 32'h1);
        chk("t1_gid", 32'(grant_id), 0);
        chk("t1_go", 32'(uart_go), 1);
        chk("t1_gv", 32'(grant_valid), 1);
        chk("t1_data", 32'(uart_data), 32'h55);
        req = '0;
        @(negedge clk);
        chk("t1_ack_pulse", 32'(ack), 0);
        wait_done("t1_done_wait");
        chk("t1_go_low", 32'(uart_go), 0);
        chk("t1_gv_release", 32'(grant_valid), 1);
        @(negedge clk);
        chk("t1_gv_idle", 32'(grant_valid), 0);
        chk("t1_go_idle", 32'(uart_go), 0);
        chk("t1_done_once", 32'(done_cnt), 1);

        // asynchronous reset in the middle of a byte
        req = 4'b0100; req_data[23:16] = 8'h77;
        wait_ack("t2_ack_wait", a);
        req = '0;
        repeat (12) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t2_go", 32'(uart_go), 0);
        chk("t2_gv", 32'(grant_valid), 0);
        chk("t2_data", 32'(uart_data), 0);
        chk("t2_gid", 32'(grant_id), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // all four request continuously: rotation starts at requester 0
        req_data = 32'hA3A2A1A0;
        for (int k = 0; k < 5; k++) exp_q.push_back('{k % 4, 8'hA0 + 8'(k % 4)});
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack("t3_ack_wait", a);
            chk("t3_ack_order", 32'(a), 32'(4'b1 << (k % 4)));
            if (k == 4) req = '0;
        end
        wait_empty("t3_drain");

        // locked multi-byte message from requester 2 while requester 1 waits
        exp_q.push_back('{2, 8'hB0}); exp_q.push_back('{2, 8'hB1});
        exp_q.push_back('{2, 8'hB2}); exp_q.push_back('{1, 8'hC1});
        lock = 4'b0100; req = 4'b0100; req_data[23:16] = 8'hB0;
        wait_ack("t4_ack0_wait", a);
        chk("t4_ack0", 32'(a), 32'h4);
        req[1] = 1'b1; req_data[15:8] = 8'hC1; req_data[23:16] = 8'hB1;
        wait_ack("t4_ack1_wait", a);
        chk("t4_ack1", 32'(a), 32'h4);
        req_data[23:16] = 8'hB2;
        wait_ack("t4_ack2_wait", a);
        chk("t4_ack2", 32'(a), 32'h4);
        req[2] = 1'b0; lock = '0;
        wait_ack("t4_ack3_wait", a);
        chk("t4_ack3", 32'(a), 32'h2);
        req = '0;
        wait_empty("t4_drain");

        // start timeout: transmitter never answers
        dc = done_cnt;
        tx_dead = 1'b1;
        req_data[7:0] = 8'h11; req_data[15:8] = 8'h22; req = 4'b0011;
        wait_ack("t5_ack0_wait", a);
        chk("t5_ack0", 32'(a), 32'h1);
        req[0] = 1'b0;
        count_to_err(n);
        chk("t5_err_delay", 32'(n), 15);
        chk("t5_go_after_err", 32'(uart_go), 0);
        n = 0;
        do begin @(negedge clk); n++; end while (ack == 0 && n < 50);
        chk("t5_next_delay", 32'(n), 2);
        chk("t5_next_ack", 32'(ack), 32'h2);
        req = '0;
        count_to_err(n);
        chk("t5_err2_delay", 32'(n), 15);
        tx_dead = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt), 32'(dc));

        // a one-cycle request glitch during another grant is never served
        ack_seen = '0;
        req = 4'b0010; req_data[15:8] = 8'hD1; exp_q.push_back('{1, 8'hD1});
        wait_ack("t6_ack_wait", a);
        chk("t6_ack", 32'(a), 32'h2);
        req = '0;
        repeat (5) @(negedge clk);
        req[3] = 1'b1; req_data[31:24] = 8'hEE;
        @(negedge clk);
        req[3] = 1'b0;
        wait_empty("t6_drain");
        repeat (5) @(negedge clk);
        chk("t6_no_ack3", 32'(ack_seen[3]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
